// File: rtl/load_store_unit.sv
// RV32I load/store unit: byte/half/word loads with sign/zero extension and
// byte/half stores via read-modify-write on a word-only memory port.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   req_*                CPU request (valid/ready), funct3 width code, address, data
//   resp_*               one-cycle response pulse with load data and fault flags
//   mem_read, mem_write  memory strobes (never together)
//   address, write_data  word-aligned address and full-word store data
//   read_data            memory word, valid in the same cycle as mem_read
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned,
    output logic        resp_illegal,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] address,
    output logic [31:0] write_data,
    input  logic [31:0] read_data
);

    typedef enum logic [2:0] {
        IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  f3_q, f3_d;
    logic [15:0] wdata_q, wdata_d;

    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_mis_q, resp_mis_d;
    logic        resp_ill_q, resp_ill_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [31:0] address_q, address_d;
    logic [31:0] write_data_q, write_data_d;

    logic        illegal;
    logic        misaligned;

    function automatic logic [31:0] extract(
        input logic [31:0] word,
        input logic [1:0]  off,
        input logic [2:0]  f3
    );
        logic [7:0]  b;
        logic [15:0] h;
        unique case (off)
            2'd0: b = word[7:0];
            2'd1: b = word[15:8];
            2'd2: b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        unique case (f3)
            3'b000: extract = {{24{b[7]}}, b};
            3'b100: extract = {24'd0, b};
            3'b001: extract = {{16{h[15]}}, h};
            3'b101: extract = {16'd0, h};
            default: extract = word;
        endcase
    endfunction

    // Replace only the addressed lane of the old word with the new store data.
    function automatic logic [31:0] merge(
        input logic [31:0] old,
        input logic [15:0] wd,
        input logic [1:0]  off,
        input logic        half
    );
        logic [31:0] m;
        m = old;
        if (half) begin
            if (off[1]) m[31:16] = wd;
            else        m[15:0]  = wd;
        end else begin
            unique case (off)
                2'd0: m[7:0]   = wd[7:0];
                2'd1: m[15:8]  = wd[7:0];
                2'd2: m[23:16] = wd[7:0];
                default: m[31:24] = wd[7:0];
            endcase
        end
        merge = m;
    endfunction

    // Illegal takes priority, so misaligned only needs the legal width codes.
    always_comb begin
        if (req_write)
            illegal = !(req_funct3 == 3'b000 || req_funct3 == 3'b001 ||
                        req_funct3 == 3'b010);
        else
            illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
        unique case (req_funct3[1:0])
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = (req_addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        off_d        = off_q;
        f3_d         = f3_q;
        wdata_d      = wdata_q;
        req_ready_d  = 1'b0;
        resp_valid_d = 1'b0;
        resp_rdata_d = 32'd0;
        resp_mis_d   = 1'b0;
        resp_ill_d   = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        address_d    = 32'd0;
        write_data_d = 32'd0;
        unique case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid) begin
                    off_d       = req_addr[1:0];
                    f3_d        = req_funct3;
                    wdata_d     = req_wdata[15:0];
                    req_ready_d = 1'b0;
                    if (illegal || misaligned) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_ill_d   = illegal;
                        resp_mis_d   = !illegal;
                    end else begin
                        address_d = {req_addr[31:2], 2'b00};
                        if (!req_write) begin
                            state_d    = LOAD;
                            mem_read_d = 1'b1;
                        end else if (req_funct3 == 3'b010) begin
                            state_d      = STORE;
                            mem_write_d  = 1'b1;
                            write_data_d = req_wdata;
                        end else begin
                            state_d    = RMW_RD;
                            mem_read_d = 1'b1;
                        end
                    end
                end
            end
            LOAD: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = extract(read_data, off_q, f3_q);
            end
            STORE: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
            end
            RMW_RD: begin
                state_d      = RMW_WR;
                mem_write_d  = 1'b1;
                address_d    = address_q;
                write_data_d = merge(read_data, wdata_q, off_q, f3_q[0]);
            end
            RMW_WR: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
            end
            RESP: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            off_q        <= 2'd0;
            f3_q         <= 3'd0;
            wdata_q      <= 16'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_mis_q   <= 1'b0;
            resp_ill_q   <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            address_q    <= 32'd0;
            write_data_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            off_q        <= off_d;
            f3_q         <= f3_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_mis_q   <= resp_mis_d;
            resp_ill_q   <= resp_ill_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            address_q    <= address_d;
            write_data_q <= write_data_d;
        end
    end

    assign req_ready       = req_ready_q;
    assign resp_valid      = resp_valid_q;
    assign resp_rdata      = resp_rdata_q;
    assign resp_misaligned = resp_mis_q;
    assign resp_illegal    = resp_ill_q;
    assign mem_read        = mem_read_q;
    assign mem_write       = mem_write_q;
    assign address         = address_q;
    assign write_data      = write_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a word memory model and a
// scoreboard queue popped by an independent response monitor.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic        resp_illegal;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;

    load_store_unit dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_misaligned(resp_misaligned), .resp_illegal(resp_illegal),
        .mem_read(mem_read), .mem_write(mem_write),
        .address(address), .write_data(write_data),
        .read_data(read_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [31:0] mem [0:255];
    logic        mem_clr = 1'b0;
    assign read_data = mem[address[9:2]];

    always @(posedge clk or posedge mem_clr) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
            mem[64] <= 32'h8899AABB;
        end else if (mem_write) begin
            mem[address[9:2]] <= write_data;
        end
    end

    typedef struct {
        int          id;
        logic [31:0] rdata;
        logic        mis;
        logic        ill;
        int          lat;
        int          nrd;
        int          nwr;
        logic [31:0] waddr;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   rd_cnt = 0;
    int   wr_cnt = 0;
    int   overlap = 0;

    task automatic chk(input string nm, input int id,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (vector %0d): got %h expected %h",
                     nm, id, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            rd_cnt = 0;
            wr_cnt = 0;
        end else begin
            if (mem_read && mem_write) overlap++;
            if (mem_read) rd_cnt++;
            if (mem_write) wr_cnt++;
            if ((mem_read || mem_write) && q.size() > 0)
                chk("mem_address", q[0].id, address, q[0].waddr);
            if (resp_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_resp", -1, 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("rdata", e.id, resp_rdata, e.rdata);
                    chk("misaligned", e.id, {31'd0, resp_misaligned},
                        {31'd0, e.mis});
                    chk("illegal", e.id, {31'd0, resp_illegal},
                        {31'd0, e.ill});
                    chk("latency", e.id, cyc - e.acc + 1, e.lat);
                    chk("reads", e.id, rd_cnt, e.nrd);
                    chk("writes", e.id, wr_cnt, e.nwr);
                end
                rd_cnt = 0;
                wr_cnt = 0;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic op(input int id, input logic w, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] r, input logic mis, input logic ill,
                      input int lat, input int nrd, input int nwr,
                      input bit push);
        int   n;
        exp_t e;
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = d;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", id, 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        e.id    = id;
        e.rdata = r;
        e.mis   = mis;
        e.ill   = ill;
        e.lat   = lat;
        e.nrd   = nrd;
        e.nwr   = nwr;
        e.waddr = {a[31:2], 2'b00};
        e.acc   = cyc + 1;
        if (push) q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_done();
        int n;
        req_valid = 1'b0;
        n = 0;
        while ((q.size() != 0 || !req_ready) && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (q.size() != 0 || !req_ready)
            chk("resp_timeout", -1, 32'd0, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        rst        = 1'b1;
        mem_clr    = 1'b1;
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h100;
        req_wdata  = 32'hDEADBEEF;
        #1 mem_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 0, {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", 0, {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", 0, resp_rdata, 32'd0);
        chk("rst_resp_mis", 0, {31'd0, resp_misaligned}, 32'd0);
        chk("rst_resp_ill", 0, {31'd0, resp_illegal}, 32'd0);
        chk("rst_mem_read", 0, {31'd0, mem_read}, 32'd0);
        chk("rst_mem_write", 0, {31'd0, mem_write}, 32'd0);
        chk("rst_address", 0, address, 32'd0);
        chk("rst_write_data", 0, write_data, 32'd0);
        chk("rst_mem_kept", 0, mem[64], 32'h8899AABB);
        req_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // id, w, f3, addr, wdata, rdata, mis, ill, lat, nrd, nwr, push
        op(1, 0, 3'b000, 32'h101, 0, 32'hFFFFFFAA, 0, 0, 2, 1, 0, 1);
        wait_done();
        op(2, 0, 3'b100, 32'h101, 0, 32'h000000AA, 0, 0, 2, 1, 0, 1);
        wait_done();
        op(3, 1, 3'b000, 32'h102, 32'h12345655, 0, 0, 0, 3, 1, 1, 1);
        wait_done();
        chk("mem_after_sb", 3, mem[64], 32'h8855AABB);
        op(4, 1, 3'b001, 32'h102, 32'h0000CAFE, 0, 0, 0, 3, 1, 1, 1);
        wait_done();
        chk("mem_after_sh", 4, mem[64], 32'hCAFEAABB);
        op(5, 0, 3'b101, 32'h102, 0, 32'h0000CAFE, 0, 0, 2, 1, 0, 1);
        wait_done();
        op(6, 0, 3'b001, 32'h102, 0, 32'hFFFFCAFE, 0, 0, 2, 1, 0, 1);
        wait_done();
        op(7, 0, 3'b000, 32'h103, 0, 32'hFFFFFFCA, 0, 0, 2, 1, 0, 1);
        wait_done();
        op(8, 0, 3'b010, 32'h100, 0, 32'hCAFEAABB, 0, 0, 2, 1, 0, 1);
        wait_done();
        op(9, 0, 3'b101, 32'h100, 0, 32'h0000AABB, 0, 0, 2, 1, 0, 1);
        wait_done();
        op(10, 0, 3'b001, 32'h100, 0, 32'hFFFFAABB, 0, 0, 2, 1, 0, 1);
        wait_done();
        op(11, 1, 3'b000, 32'h103, 32'h0000007F, 0, 0, 0, 3, 1, 1, 1);
        wait_done();
        chk("mem_after_sb3", 11, mem[64], 32'h7FFEAABB);
        op(12, 0, 3'b100, 32'h103, 0, 32'h0000007F, 0, 0, 2, 1, 0, 1);
        wait_done();

        op(20, 0, 3'b010, 32'h102, 0, 0, 1, 0, 1, 0, 0, 1);
        wait_done();
        op(21, 1, 3'b011, 32'h100, 32'h1, 0, 0, 1, 1, 0, 0, 1);
        wait_done();
        op(22, 0, 3'b110, 32'h101, 0, 0, 0, 1, 1, 0, 0, 1);
        wait_done();
        op(23, 0, 3'b111, 32'h103, 0, 0, 0, 1, 1, 0, 0, 1);
        wait_done();
        op(24, 1, 3'b010, 32'h103, 32'h5, 0, 1, 0, 1, 0, 0, 1);
        wait_done();
        op(25, 1, 3'b001, 32'h101, 32'h5, 0, 1, 0, 1, 0, 0, 1);
        wait_done();
        op(26, 0, 3'b101, 32'h103, 0, 0, 1, 0, 1, 0, 0, 1);
        wait_done();
        op(27, 1, 3'b100, 32'h101, 32'h5, 0, 0, 1, 1, 0, 0, 1);
        wait_done();
        chk("mem_after_faults", 27, mem[64], 32'h7FFEAABB);

        // Abort an SB while its write strobe is up.
        op(30, 1, 3'b000, 32'h100, 32'h00000011, 0, 0, 0, 3, 1, 1, 0);
        req_valid = 1'b0;
        for (int n = 0; n < 10 && !mem_write; n++) @(negedge clk);
        chk("abort_saw_write", 30, {31'd0, mem_write}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_write_drop", 30, {31'd0, mem_write}, 32'd0);
        chk("abort_read_low", 30, {31'd0, mem_read}, 32'd0);
        chk("abort_ready", 30, {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_mem_kept", 30, mem[64], 32'h7FFEAABB);
        chk("abort_idle_ready", 30, {31'd0, req_ready}, 32'd1);

        // Back-to-back with req_valid held high throughout.
        op(40, 1, 3'b010, 32'h200, 32'hA5A55A5A, 0, 0, 0, 2, 0, 1, 1);
        op(41, 0, 3'b010, 32'h200, 0, 32'hA5A55A5A, 0, 0, 2, 1, 0, 1);
        op(42, 1, 3'b010, 32'h204, 32'h01020304, 0, 0, 0, 2, 0, 1, 1);
        wait_done();
        chk("mem_200", 40, mem[128], 32'hA5A55A5A);
        chk("mem_204", 42, mem[129], 32'h01020304);
        chk("strobe_overlap", 0, overlap, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
